// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : softmax_pkg
// Description : Shared constants, mode encodings and helper functions for the
//               softmax-approximation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  localparam int DW    = 16;
  localparam int LANES = 64;

  // Segmentation / group mode encodings (4-bit)
  localparam logic [3:0] MODE_SEG16   = 4'd0;
  localparam logic [3:0] MODE_SEG32   = 4'd1;
  localparam logic [3:0] MODE_ROW     = 4'd2;
  localparam logic [3:0] MODE_GRP_MIN = 4'd3;
  localparam logic [3:0] MODE_GRP_MAX = 4'd13;

  // Most negative lane value; also the "exp underflows to zero" marker
  localparam logic [DW-1:0] NEG_MAX = 16'h8000;

  function automatic logic is_grouped(input logic [3:0] mode);
    return (mode >= MODE_GRP_MIN) && (mode <= MODE_GRP_MAX);
  endfunction

  // Rows per group: mode 3 -> 2 rows ... mode 13 -> 12 rows; 1 otherwise
  function automatic logic [3:0] grp_len(input logic [3:0] mode);
    if (is_grouped(mode)) begin
      return mode - 4'd1;
    end
    return 4'd1;
  endfunction

endpackage : softmax_pkg
`default_nettype wire

// File: rtl/lane_sat_sub.sv
`default_nettype none
// ============================================================================
// Module      : lane_sat_sub
// Description : Combinational per-lane saturating subtract d = x - m.
//               Positive differences clamp to 0 and raise o_viol; results
//               below -32768 clamp to 16'h8000.
//               Optional macro MAX_SUB_FLOOR_EN: results below FLOOR_THR are
//               forced to 16'h8000 after saturation.
// Ports       : i_x    - lane data (signed)
//               i_m    - lane maximum (signed)
//               o_diff - saturated difference
//               o_viol - lane exceeded its maximum
// Revision    : 1.0 - initial release
// ============================================================================
module lane_sat_sub
  import softmax_pkg::*;
`ifdef MAX_SUB_FLOOR_EN
#(
  parameter logic [DW-1:0] FLOOR_THR = 16'hC000
)
`endif
(
  input  logic [DW-1:0] i_x,
  input  logic [DW-1:0] i_m,
  output logic [DW-1:0] o_diff,
  output logic          o_viol
);

  logic signed [DW:0] w_d;
  logic [DW-1:0]      w_sat;

  assign w_d = $signed({i_x[DW-1], i_x}) - $signed({i_m[DW-1], i_m});

  always_comb begin
    w_sat  = w_d[DW-1:0];
    o_viol = 1'b0;
    if (!w_d[DW] && (w_d != '0)) begin
      // x above its max: clamp to zero and flag it
      w_sat  = '0;
      o_viol = 1'b1;
    end else if (w_d[DW] && !w_d[DW-1]) begin
      // negative with bit 15 clear means d < -32768
      w_sat = NEG_MAX;
    end
  end

`ifdef MAX_SUB_FLOOR_EN
  assign o_diff = ($signed(w_sat) < $signed(FLOOR_THR)) ? NEG_MAX : w_sat;
`else
  assign o_diff = w_sat;
`endif

endmodule : lane_sat_sub
`default_nettype wire

// File: rtl/max_subtract.sv
`default_nettype none
// ============================================================================
// Module      : max_subtract
// Description : Subtracts the applicable segment/row/group maximum from each
//               of 64 signed 16-bit lanes (saturating), tags first/last row
//               of multi-row groups, and keeps a sticky max-violation flag.
//               Two enabled cycles of latency.
//               Optional macro MAX_SUB_FLOOR_EN enables the FLOOR_THR floor.
// Ports       : i_clk, i_rst (sync, active-high), i_en (global hold)
//               i_valid, i_length_mode, i_in_flat   - input row
//               i_max16_0..3, i_max32_0..1, i_max64_0, i_global_max - maxima
//               o_valid, o_length_mode_byp, o_diff_flat - output row
//               o_group_first, o_group_last, o_max_violation - tags/flag
// Revision    : 1.0 - initial release
// ============================================================================
module max_subtract
  import softmax_pkg::*;
`ifdef MAX_SUB_FLOOR_EN
#(
  parameter logic [DW-1:0] FLOOR_THR = 16'hC000
)
`endif
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_valid,
  input  logic [DW-1:0]         i_global_max,
  input  logic [3:0]            i_length_mode,
  input  logic [LANES*DW-1:0]   i_in_flat,
  input  logic [DW-1:0]         i_max64_0,
  input  logic [DW-1:0]         i_max32_0,
  input  logic [DW-1:0]         i_max32_1,
  input  logic [DW-1:0]         i_max16_0,
  input  logic [DW-1:0]         i_max16_1,
  input  logic [DW-1:0]         i_max16_2,
  input  logic [DW-1:0]         i_max16_3,
  output logic                  o_valid,
  output logic [3:0]            o_length_mode_byp,
  output logic [LANES*DW-1:0]   o_diff_flat,
  output logic                  o_group_first,
  output logic                  o_group_last,
  output logic                  o_max_violation
);

  logic [3:0][DW-1:0]       w_max16;
  logic [1:0][DW-1:0]       w_max32;
  logic [LANES-1:0][DW-1:0] w_max_sel;
  logic [LANES-1:0][DW-1:0] w_diff;
  logic [LANES-1:0]         w_viol;
  logic                     w_seg16;
  logic                     w_seg32;
  logic                     w_row_like;
  logic                     w_grouped;
  logic [3:0]               w_len;
  logic [3:0]               w_eff_cnt;
  logic                     w_first;
  logic                     w_last;
  logic [3:0]               w_cnt_nxt;
  logic [3:0]               w_last_mode_nxt;

  // Stage 1
  logic                     r1_valid;
  logic [3:0]               r1_mode;
  logic [LANES-1:0][DW-1:0] r1_data;
  logic [LANES-1:0][DW-1:0] r1_max;
  logic                     r1_first;
  logic                     r1_last;
  // Stage 2
  logic                     r2_valid;
  logic [3:0]               r2_mode;
  logic [LANES-1:0][DW-1:0] r2_diff;
  logic                     r2_first;
  logic                     r2_last;
  logic                     r_viol;
  // Group tracking
  logic [3:0]               r_cnt;
  logic [3:0]               r_last_mode;

  assign w_max16 = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
  assign w_max32 = {i_max32_1, i_max32_0};

  assign w_seg16    = (i_length_mode == MODE_SEG16);
  assign w_seg32    = (i_length_mode == MODE_SEG32);
  // Modes 14 and 15 behave exactly like the whole-row mode
  assign w_row_like = (i_length_mode == MODE_ROW) || (i_length_mode > MODE_GRP_MAX);
  assign w_grouped  = is_grouped(i_length_mode);
  assign w_len      = grp_len(i_length_mode);

  // A mode change restarts the group at this row
  assign w_eff_cnt  = (i_length_mode != r_last_mode) ? 4'd0 : r_cnt;

  always_comb begin
    w_first         = 1'b0;
    w_last          = 1'b0;
    w_cnt_nxt       = 4'd0;
    w_last_mode_nxt = r_last_mode;
    if (i_valid) begin
      w_last_mode_nxt = i_length_mode;
      if (!w_grouped) begin
        w_first = 1'b1;
        w_last  = 1'b1;
      end else begin
        w_first   = (w_eff_cnt == 4'd0);
        w_last    = (w_eff_cnt == (w_len - 4'd1));
        w_cnt_nxt = w_last ? 4'd0 : (w_eff_cnt + 4'd1);
      end
    end
    // An invalid row is a bubble: it aborts the group (counter back to 0)
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign w_max_sel[k] = w_seg16    ? w_max16[k/16] :
                          w_seg32    ? w_max32[k/32] :
                          w_row_like ? i_max64_0     :
                                       i_global_max;

    lane_sat_sub
`ifdef MAX_SUB_FLOOR_EN
      #(.FLOOR_THR(FLOOR_THR))
`endif
      u_sub (
        .i_x    (r1_data[k]),
        .i_m    (r1_max[k]),
        .o_diff (w_diff[k]),
        .o_viol (w_viol[k])
      );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_valid    <= 1'b0;
      r1_mode     <= 4'd0;
      r1_data     <= '0;
      r1_max      <= '0;
      r1_first    <= 1'b0;
      r1_last     <= 1'b0;
      r2_valid    <= 1'b0;
      r2_mode     <= 4'd0;
      r2_diff     <= '0;
      r2_first    <= 1'b0;
      r2_last     <= 1'b0;
      r_viol      <= 1'b0;
      r_cnt       <= 4'd0;
      r_last_mode <= 4'd0;
    end else if (i_en) begin
      r1_valid    <= i_valid;
      r1_mode     <= i_length_mode;
      r1_data     <= i_in_flat;
      r1_max      <= w_max_sel;
      r1_first    <= w_first;
      r1_last     <= w_last;
      r_cnt       <= w_cnt_nxt;
      r_last_mode <= w_last_mode_nxt;

      r2_valid    <= r1_valid;
      r2_mode     <= r1_mode;
      r2_diff     <= w_diff;
      r2_first    <= r1_first;
      r2_last     <= r1_last;
      // Garbage lanes of bubble rows must not set the sticky flag
      if (r1_valid && (|w_viol)) begin
        r_viol <= 1'b1;
      end
    end
  end

  assign o_valid           = r2_valid;
  assign o_length_mode_byp = r2_mode;
  assign o_diff_flat       = r2_diff;
  assign o_group_first     = r2_first;
  assign o_group_last      = r2_last;
  assign o_max_violation   = r_viol;

endmodule : max_subtract
`default_nettype wire

// File: tb/tb_max_subtract.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_subtract
// Description : Directed self-checking bench for max_subtract.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_subtract;

  localparam int LANES = 64;
  localparam int NG    = 16;

  logic              clk;
  logic              i_rst;
  logic              i_en;
  logic              i_valid;
  logic [15:0]       i_global_max;
  logic [3:0]        i_length_mode;
  logic [1023:0]     i_in_flat;
  logic [15:0]       i_max64_0;
  logic [15:0]       i_max32_0, i_max32_1;
  logic [15:0]       i_max16_0, i_max16_1, i_max16_2, i_max16_3;
  logic              o_valid;
  logic [3:0]        o_length_mode_byp;
  logic [1023:0]     o_diff_flat;
  logic              o_group_first;
  logic              o_group_last;
  logic              o_max_violation;

  int                n_vec = 0;
  int                n_err = 0;
  logic [1023:0]     exp_bus;

  // Group-tracking table: mode, valid, expected first, expected last
  logic [3:0] g_mode  [NG] = '{4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,4'd5,
                               4'd5,4'd5,4'd5,4'd6,4'd6,4'd2,4'd3,4'd3};
  logic       g_valid [NG] = '{1,1,1,1,1,1,0,1,1,0,1,1,1,1,1,1};
  logic       g_first [NG] = '{1,0,0,0,1,0,0,1,0,0,1,1,0,1,1,0};
  logic       g_last  [NG] = '{0,0,0,1,0,0,0,0,0,0,0,0,0,1,0,1};

  max_subtract dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_en              (i_en),
    .i_valid           (i_valid),
    .i_global_max      (i_global_max),
    .i_length_mode     (i_length_mode),
    .i_in_flat         (i_in_flat),
    .i_max64_0         (i_max64_0),
    .i_max32_0         (i_max32_0),
    .i_max32_1         (i_max32_1),
    .i_max16_0         (i_max16_0),
    .i_max16_1         (i_max16_1),
    .i_max16_2         (i_max16_2),
    .i_max16_3         (i_max16_3),
    .o_valid           (o_valid),
    .o_length_mode_byp (o_length_mode_byp),
    .o_diff_flat       (o_diff_flat),
    .o_group_first     (o_group_first),
    .o_group_last      (o_group_last),
    .o_max_violation   (o_max_violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [1023:0] expv);
    int bad;
    n_vec++;
    assert (o_diff_flat === expv) else begin
      n_err++;
      bad = 0;
      for (int k = LANES - 1; k >= 0; k--) begin
        if (o_diff_flat[16*k +: 16] !== expv[16*k +: 16]) bad = k;
      end
      $error("FAIL %s: lane %0d got %h, want %h", tag, bad,
             o_diff_flat[16*bad +: 16], expv[16*bad +: 16]);
    end
  endtask

  task automatic idle();
    i_valid       = 1'b0;
    i_length_mode = 4'd2;
    i_in_flat     = '0;
    i_global_max  = '0;
    i_max64_0     = '0;
    i_max32_0     = '0;
    i_max32_1     = '0;
    i_max16_0     = '0;
    i_max16_1     = '0;
    i_max16_2     = '0;
    i_max16_3     = '0;
  endtask

  task automatic row(input logic [3:0] mode, input logic [15:0] x);
    i_valid       = 1'b1;
    i_length_mode = mode;
    i_in_flat     = {LANES{x}};
  endtask

  initial begin
    idle();
    i_en  = 1'b1;
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;

    // Reset state
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk_bus("rst_diff", '0);
    chk("rst_byp", {28'd0, o_length_mode_byp}, 32'd0);
    chk("rst_flags", {30'd0, o_group_first, o_group_last}, 32'd0);
    chk("rst_viol", {31'd0, o_max_violation}, 32'd0);

    // Invalid row with x > m must not set the sticky flag
    row(4'd2, 16'h0005);
    i_valid   = 1'b0;
    i_max64_0 = 16'h0003;
    step(); step(); step();
    chk("bubble_noviol", {31'd0, o_max_violation}, 32'd0);
    chk("bubble_valid", {31'd0, o_valid}, 32'd0);

    // Mode 2: x == max -> zero
    idle();
    row(4'd2, 16'h0100);
    i_max64_0 = 16'h0100;
    step();
    i_valid = 1'b0;
    step();
    chk("m2_valid", {31'd0, o_valid}, 32'd1);
    chk_bus("m2_diff", '0);
    chk("m2_flags", {30'd0, o_group_first, o_group_last}, 32'd3);
    chk("m2_byp", {28'd0, o_length_mode_byp}, 32'd2);
    chk("m2_viol", {31'd0, o_max_violation}, 32'd0);

    // Mode 0: quarter-row maxima
    idle();
    i_valid          = 1'b1;
    i_length_mode    = 4'd0;
    i_in_flat[15:0]  = 16'h0010;
    i_in_flat[271:256] = 16'h0020;
    i_max16_0 = 16'h0010;
    i_max16_1 = 16'h0040;
    i_max64_0 = 16'h1111;
    step();
    i_valid = 1'b0;
    step();
    exp_bus = '0;
    for (int k = 0; k < LANES; k++) begin
      if (k == 0)       exp_bus[16*k +: 16] = 16'h0000;
      else if (k < 16)  exp_bus[16*k +: 16] = 16'hFFF0;
      else if (k == 16) exp_bus[16*k +: 16] = 16'hFFE0;
      else if (k < 32)  exp_bus[16*k +: 16] = 16'hFFC0;
      else              exp_bus[16*k +: 16] = 16'h0000;
    end
    chk("m0_lane0", {16'd0, o_diff_flat[15:0]}, 32'h0000);
    chk("m0_lane16", {16'd0, o_diff_flat[271:256]}, 32'hFFE0);
    chk_bus("m0_diff", exp_bus);
    chk("m0_byp", {28'd0, o_length_mode_byp}, 32'd0);

    // Mode 1: half-row maxima
    idle();
    row(4'd1, 16'h0000);
    i_max32_0 = 16'h0020;
    i_max32_1 = 16'h0005;
    i_max64_0 = 16'h7000;
    step();
    i_valid = 1'b0;
    step();
    chk_bus("m1_diff", {{32{16'hFFFB}}, {32{16'hFFE0}}});

    // Mode 3: group maximum
    idle();
    row(4'd3, 16'h0800);
    i_global_max = 16'h1000;
    i_max64_0    = 16'h0800;
    step();
    i_valid = 1'b0;
    step();
    chk_bus("m3_diff", {LANES{16'hF800}});
    chk("m3_flags", {30'd0, o_group_first, o_group_last}, 32'd2);

    // Mode 14 behaves as mode 2
    idle();
    row(4'd14, 16'h0000);
    i_max64_0    = 16'h0200;
    i_global_max = 16'h7000;
    step();
    i_valid = 1'b0;
    step();
    chk_bus("m14_diff", {LANES{16'hFE00}});
    chk("m14_flags", {30'd0, o_group_first, o_group_last}, 32'd3);

    // Negative saturation
    idle();
    row(4'd2, 16'h8000);
    i_max64_0 = 16'h7FFF;
    step();
    i_max64_0 = 16'h0001;
    step();
    i_valid = 1'b0;
    chk_bus("sat_min", {LANES{16'h8000}});
    step();
    chk_bus("sat_m1", {LANES{16'h8000}});
    chk("sat_viol", {31'd0, o_max_violation}, 32'd0);

    // Positive difference: clamp and sticky flag
    idle();
    row(4'd2, 16'h0005);
    i_max64_0 = 16'h0003;
    step();
    i_valid = 1'b0;
    step();
    chk_bus("pos_clamp", '0);
    chk("pos_viol", {31'd0, o_max_violation}, 32'd1);
    idle();
    for (int i = 0; i < 10; i++) begin
      row(4'd2, 16'h0000);
      step();
    end
    i_valid = 1'b0;
    step(); step();
    chk("viol_sticky", {31'd0, o_max_violation}, 32'd1);

    // Group tracking table (2-cycle lag between apply and check)
    idle();
    for (int i = 0; i <= NG; i++) begin
      if (i < NG) begin
        i_valid       = g_valid[i];
        i_length_mode = g_mode[i];
      end else begin
        i_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        chk($sformatf("grp%0d_valid", i-1), {31'd0, o_valid}, {31'd0, g_valid[i-1]});
        chk($sformatf("grp%0d_fl", i-1), {30'd0, o_group_first, o_group_last},
            {30'd0, g_first[i-1], g_last[i-1]});
        if (g_valid[i-1])
          chk($sformatf("grp%0d_byp", i-1), {28'd0, o_length_mode_byp}, {28'd0, g_mode[i-1]});
      end
    end

    // Enable hold mid-stream (mode 5 group)
    idle();
    row(4'd5, 16'h0010); i_global_max = 16'h0020;  // X
    step();
    row(4'd5, 16'h0001); i_global_max = 16'h0002;  // Y
    step();
    i_en = 1'b0;
    row(4'd5, 16'h0000); i_global_max = 16'h0003;  // Z presented during hold
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d_diff", i), {16'd0, o_diff_flat[15:0]}, 32'hFFF0);
      chk($sformatf("hold%0d_fl", i), {29'd0, o_valid, o_group_first, o_group_last}, 32'd6);
    end
    i_en = 1'b1;
    step();
    chk_bus("resume_Y", {LANES{16'hFFFF}});
    chk("resume_Y_fl", {29'd0, o_valid, o_group_first, o_group_last}, 32'd4);
    row(4'd5, 16'h0000); i_global_max = 16'h0000;  // W
    step();
    chk_bus("resume_Z", {LANES{16'hFFFD}});
    chk("resume_Z_fl", {29'd0, o_valid, o_group_first, o_group_last}, 32'd4);
    i_valid = 1'b0;
    step();
    chk("resume_W_fl", {29'd0, o_valid, o_group_first, o_group_last}, 32'd5);

    // Reset with rows in flight
    idle();
    row(4'd5, 16'h0001); i_global_max = 16'h0004;
    step();
    row(4'd5, 16'h0002);
    step();
    row(4'd5, 16'h0003);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("frst_valid", {31'd0, o_valid}, 32'd0);
    chk_bus("frst_diff", '0);
    chk("frst_byp", {28'd0, o_length_mode_byp}, 32'd0);
    chk("frst_flags", {30'd0, o_group_first, o_group_last}, 32'd0);
    chk("frst_viol", {31'd0, o_max_violation}, 32'd0);
    i_valid = 1'b0;
    step();
    chk("frst_next", {29'd0, o_valid, o_group_first, o_group_last}, 32'd0);
    step();
    chk("frst_next2", {29'd0, o_valid, o_group_first, o_group_last}, 32'd0);

    // Floor threshold behaviour
    idle();
    row(4'd2, 16'h8100);
    step();
    row(4'd2, 16'hD000);
    step();
    i_valid = 1'b0;
`ifdef MAX_SUB_FLOOR_EN
    chk_bus("floor_below", {LANES{16'h8000}});
`else
    chk_bus("floor_below", {LANES{16'h8100}});
`endif
    step();
    chk_bus("floor_above", {LANES{16'hD000}});
    chk("floor_viol", {31'd0, o_max_violation}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_max_subtract
`default_nettype wire
